// File: rtl/pma_rx_deserializer.sv
// Serial-to-parallel receive stage: rebuilds DATA_WIDTH-bit words aligned on K28.5 commas.
// Optional feature macro RX_COMMA_FLAG_EN adds Comma_Det, flagging emitted comma words.
module pma_rx_deserializer #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter logic [6:0]  COMMA_P    = 7'h7C,
  parameter logic [6:0]  COMMA_N    = 7'h03,
  parameter int unsigned ERR_THR    = 4
) (
  input  logic                  Bit_Rate_Clk,
  input  logic                  Rst,
  input  logic                  Serial_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid,
`ifdef RX_COMMA_FLAG_EN
  output logic                  Comma_Det,
`endif
  output logic                  Sync_Lock
);

  localparam int unsigned     CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned     ErrW    = (ERR_THR > 1) ? $clog2(ERR_THR + 1) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);
  localparam logic [ErrW-1:0] ErrLast = ErrW'(ERR_THR - 1);

  typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] window_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [ErrW-1:0]       err_cnt_q;

  logic comma;
  logic boundary;
  logic emit;
  logic realign;

  // Oldest received bit sits at window_q[0], so [6:0] holds the first seven bits of a symbol.
  always_comb begin
    comma    = (window_q[6:0] == COMMA_P) || (window_q[6:0] == COMMA_N);
    boundary = (bit_cnt_q == LastBit);
    emit     = 1'b0;
    realign  = 1'b0;
    unique case (state_q)
      StHunt: begin
        emit    = comma;
        realign = comma;
      end
      StSync: begin
        realign = comma && !boundary;
        emit    = realign || boundary;
      end
      StLocked: emit = boundary;
      default: ;
    endcase
  end

  always_ff @(posedge Bit_Rate_Clk) begin
    if (Rst) begin
      window_q   <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      state_q    <= StHunt;
      Data_Out   <= '0;
      Data_Valid <= 1'b0;
      Sync_Lock  <= 1'b0;
`ifdef RX_COMMA_FLAG_EN
      Comma_Det  <= 1'b0;
`endif
    end else begin
      window_q   <= {Serial_In, window_q[DATA_WIDTH-1:1]};
      bit_cnt_q  <= (realign || boundary) ? '0 : bit_cnt_q + 1'b1;
      Data_Valid <= emit;
      if (emit) begin
        Data_Out <= window_q;
      end
`ifdef RX_COMMA_FLAG_EN
      Comma_Det  <= emit && comma;
`endif
      unique case (state_q)
        StHunt: begin
          if (comma) begin
            state_q <= StSync;
          end
        end
        StSync: begin
          if (comma && boundary) begin
            state_q   <= StLocked;
            Sync_Lock <= 1'b1;
            err_cnt_q <= '0;
          end
        end
        StLocked: begin
          // Off-boundary commas only count errors; alignment is never moved while locked.
          if (comma) begin
            if (boundary) begin
              err_cnt_q <= '0;
            end else if (err_cnt_q == ErrLast) begin
              state_q   <= StHunt;
              Sync_Lock <= 1'b0;
              err_cnt_q <= '0;
            end else begin
              err_cnt_q <= err_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q   <= StHunt;
          Sync_Lock <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pma_rx_deserializer.sv
// Bench for pma_rx_deserializer: directed alignment scenarios plus random traffic,
// every cycle compared against a bit-history reference model.
module tb_pma_rx_deserializer;

  localparam int W = 10;
  localparam logic [W-1:0] K_RDN = 10'h17C;
  localparam logic [W-1:0] K_RDP = 10'h283;

  logic         Bit_Rate_Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Serial_In = 1'b0;
  logic [W-1:0] Data_Out;
  logic         Data_Valid;
  logic         Sync_Lock;
`ifdef RX_COMMA_FLAG_EN
  logic         Comma_Det;
`endif

  pma_rx_deserializer #(.DATA_WIDTH(W)) dut (
    .Bit_Rate_Clk (Bit_Rate_Clk),
    .Rst          (Rst),
    .Serial_In    (Serial_In),
    .Data_Out     (Data_Out),
    .Data_Valid   (Data_Valid),
`ifdef RX_COMMA_FLAG_EN
    .Comma_Det    (Comma_Det),
`endif
    .Sync_Lock    (Sync_Lock)
  );

  always #5 Bit_Rate_Clk = ~Bit_Rate_Clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
    logic         lock;
    logic         cdet;
  } pulse_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  pulse_t pulses[$];
  logic   lock_q[$];

  // Reference model: history of received bits, alignment phase, mode name.
  bit           hist[$];
  string        m_mode = "HUNT";
  int           m_since = 0;
  int           m_errs = 0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_lock = 1'b0;
  logic         m_cdet = 1'b0;

  task automatic model_edge(input logic r, input logic b);
    logic [W-1:0] w;
    logic c, on_b, emit, realign;
    if (r) begin
      hist.delete();
      for (int i = 0; i < W; i++) hist.push_back(1'b0);
      m_mode = "HUNT"; m_since = 0; m_errs = 0;
      m_valid = 1'b0; m_data = '0; m_lock = 1'b0; m_cdet = 1'b0;
    end else begin
      for (int i = 0; i < W; i++) w[i] = hist[hist.size() - W + i];
      c = (w[6:0] == 7'h7C) || (w[6:0] == 7'h03);
      on_b = ((m_since % W) == W - 1);
      emit = 1'b0;
      realign = 1'b0;
      if (m_mode == "HUNT") begin
        if (c) begin emit = 1'b1; realign = 1'b1; m_mode = "SYNC"; end
      end else if (m_mode == "SYNC") begin
        if (c && !on_b) begin
          emit = 1'b1; realign = 1'b1;
        end else if (on_b) begin
          emit = 1'b1;
          if (c) begin m_mode = "LOCKED"; m_errs = 0; end
        end
      end else begin
        emit = on_b;
        if (c && on_b) m_errs = 0;
        else if (c) begin
          m_errs++;
          if (m_errs == 4) begin m_mode = "HUNT"; m_errs = 0; end
        end
      end
      m_valid = emit;
      if (emit) m_data = w;
      m_cdet = emit && c;
      m_lock = (m_mode == "LOCKED");
      m_since = realign ? 0 : m_since + 1;
      hist.push_back(b);
      void'(hist.pop_front());
    end
  endtask

  task automatic step(input logic b, input logic r);
    pulse_t p;
    Serial_In = b;
    Rst = r;
    @(posedge Bit_Rate_Clk);
    model_edge(r, b);
    @(negedge Bit_Rate_Clk);
    cyc++;
    lock_q.push_back(Sync_Lock);
    if (Data_Valid === 1'b1) begin
      p.cyc = cyc; p.data = Data_Out; p.lock = Sync_Lock; p.cdet = 1'b0;
`ifdef RX_COMMA_FLAG_EN
      p.cdet = Comma_Det;
`endif
      pulses.push_back(p);
    end
    n_checks += 3;
    if (Data_Valid !== m_valid) begin
      n_errors++;
      $display("FAIL model_valid cyc=%0d got %b exp %b", cyc, Data_Valid, m_valid);
    end
    if (Data_Out !== m_data) begin
      n_errors++;
      $display("FAIL model_data cyc=%0d got %h exp %h", cyc, Data_Out, m_data);
    end
    if (Sync_Lock !== m_lock) begin
      n_errors++;
      $display("FAIL model_lock cyc=%0d got %b exp %b", cyc, Sync_Lock, m_lock);
    end
`ifdef RX_COMMA_FLAG_EN
    n_checks++;
    if (Comma_Det !== m_cdet) begin
      n_errors++;
      $display("FAIL model_cdet cyc=%0d got %b exp %b", cyc, Comma_Det, m_cdet);
    end
`endif
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) step(w[i], 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(logic'(i % 2), 1'b1);
      n_checks++;
      if (Data_Out !== '0 || Data_Valid !== 1'b0 || Sync_Lock !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_state got data=%h valid=%b lock=%b exp 000/0/0",
                 Data_Out, Data_Valid, Sync_Lock);
      end
    end
  endtask

  task automatic test_acquire;
    int cyc0;
    pulses.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    cyc0 = cyc;
    send_word(K_RDN);
    send_word(K_RDN);
    send_word(K_RDN);
    n_checks++;
    if (pulses.size() != 2) begin
      n_errors++;
      $display("FAIL acquire_count got %0d exp 2", pulses.size());
    end else begin
      n_checks += 2;
      if (pulses[0].cyc != cyc0 + 11 || pulses[0].data !== K_RDN || pulses[0].lock !== 1'b0) begin
        n_errors++;
        $display("FAIL acquire_first got cyc+%0d %h lock=%b exp cyc+11 17c lock=0",
                 pulses[0].cyc - cyc0, pulses[0].data, pulses[0].lock);
      end
      if (pulses[1].cyc != cyc0 + 21 || pulses[1].data !== K_RDN || pulses[1].lock !== 1'b1) begin
        n_errors++;
        $display("FAIL acquire_lock got cyc+%0d %h lock=%b exp cyc+21 17c lock=1",
                 pulses[1].cyc - cyc0, pulses[1].data, pulses[1].lock);
      end
`ifdef RX_COMMA_FLAG_EN
      n_checks++;
      if (pulses[0].cdet !== 1'b1) begin
        n_errors++;
        $display("FAIL acquire_cdet got %b exp 1", pulses[0].cdet);
      end
`endif
    end
  endtask

  task automatic test_stream;
    int cyc0;
    logic [W-1:0] exp_data [4];
    exp_data = '{10'h17C, 10'h283, 10'h155, 10'h0F0};
    pulses.delete();
    cyc0 = cyc;
    send_word(10'h283);
    send_word(10'h155);
    send_word(10'h0F0);
    send_word(K_RDN);
    n_checks++;
    if (pulses.size() != 4) begin
      n_errors++;
      $display("FAIL stream_count got %0d exp 4", pulses.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (pulses[i].cyc != cyc0 + 1 + 10 * i || pulses[i].data !== exp_data[i] ||
            pulses[i].lock !== 1'b1) begin
          n_errors++;
          $display("FAIL stream_word%0d got cyc+%0d %h lock=%b exp cyc+%0d %h lock=1", i,
                   pulses[i].cyc - cyc0, pulses[i].data, pulses[i].lock, 1 + 10 * i,
                   exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_misalign;
    int cyc0;
    pulses.delete();
    cyc0 = cyc;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_word(K_RDN);
    step(1'b0, 1'b0);
    n_checks += 3;
    if (lock_q[cyc0 + 33] !== 1'b1) begin
      n_errors++;
      $display("FAIL misalign_third got lock=%b exp 1", lock_q[cyc0 + 33]);
    end
    if (lock_q[cyc0 + 43] !== 1'b0) begin
      n_errors++;
      $display("FAIL misalign_drop got lock=%b exp 0", lock_q[cyc0 + 43]);
    end
    if (pulses.size() != 6) begin
      n_errors++;
      $display("FAIL misalign_count got %0d exp 6", pulses.size());
    end else begin
      n_checks++;
      if (pulses[4].cyc != cyc0 + 41 || pulses[5].cyc != cyc0 + 54 ||
          pulses[5].data !== K_RDN || pulses[5].lock !== 1'b0) begin
        n_errors++;
        $display("FAIL misalign_resync got cyc+%0d,+%0d %h lock=%b exp +41,+54 17c lock=0",
                 pulses[4].cyc - cyc0, pulses[5].cyc - cyc0, pulses[5].data, pulses[5].lock);
      end
    end
  endtask

  task automatic test_realign;
    int cyc0;
    pulses.delete();
    cyc0 = cyc;
    send_word(K_RDN);
    send_word(10'h155);
    send_word(K_RDN);
    step(1'b0, 1'b0);
    n_checks++;
    if (pulses.size() != 4) begin
      n_errors++;
      $display("FAIL realign_count got %0d exp 4", pulses.size());
    end else begin
      n_checks += 3;
      if (pulses[1].cyc != cyc0 + 11 || pulses[1].data !== K_RDN || pulses[1].lock !== 1'b0) begin
        n_errors++;
        $display("FAIL realign_comma got cyc+%0d %h exp cyc+11 17c",
                 pulses[1].cyc - cyc0, pulses[1].data);
      end
      if (pulses[2].cyc != cyc0 + 21 || pulses[2].data !== 10'h155) begin
        n_errors++;
        $display("FAIL realign_next got cyc+%0d %h exp cyc+21 155",
                 pulses[2].cyc - cyc0, pulses[2].data);
      end
      if (pulses[3].cyc != cyc0 + 31 || pulses[3].lock !== 1'b1) begin
        n_errors++;
        $display("FAIL realign_lock got cyc+%0d lock=%b exp cyc+31 lock=1",
                 pulses[3].cyc - cyc0, pulses[3].lock);
      end
`ifdef RX_COMMA_FLAG_EN
      n_checks++;
      if (pulses[1].cdet !== 1'b1 || pulses[2].cdet !== 1'b0) begin
        n_errors++;
        $display("FAIL realign_cdet got %b%b exp 10", pulses[1].cdet, pulses[2].cdet);
      end
`endif
    end
  endtask

  task automatic test_reset_midword;
    int cyc0;
    pulses.delete();
    cyc0 = cyc;
    for (int i = 0; i < 4; i++) step(logic'($urandom_range(0, 1)), 1'b0);
    step(logic'($urandom_range(0, 1)), 1'b1);
    n_checks++;
    if (Data_Out !== '0 || Data_Valid !== 1'b0 || Sync_Lock !== 1'b0) begin
      n_errors++;
      $display("FAIL midword_reset got data=%h valid=%b lock=%b exp 000/0/0",
               Data_Out, Data_Valid, Sync_Lock);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0);
    send_word(K_RDN);
    step(1'b0, 1'b0);
    n_checks++;
    if (pulses.size() != 1 || pulses[0].cyc != cyc0 + 46 || pulses[0].data !== K_RDN) begin
      n_errors++;
      $display("FAIL midword_reacquire got %0d pulses exp 1 at cyc+46 with 17c", pulses.size());
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: send_word(W'($urandom));
        4, 5, 6:    send_word($urandom_range(0, 1) ? K_RDN : K_RDP);
        7, 8: begin
          for (int i = 0; i < int'($urandom_range(1, 9)); i++)
            step(logic'($urandom_range(0, 1)), 1'b0);
        end
        default: begin
          for (int i = 0; i < int'($urandom_range(1, 2)); i++)
            step(logic'($urandom_range(0, 1)), 1'b1);
        end
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    @(negedge Bit_Rate_Clk);
    test_reset();
    test_acquire();
    test_stream();
    test_misalign();
    test_realign();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
